// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port plus VGA pin bundle seen by vga_frame_reader.
// master = the reader; slave = the RAM / DAC / writer side.
interface vga_frame_reader_if;
  logic        frame_ready;
  logic [11:0] rdaddress;
  logic        rden;
  logic        q;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        frame_start;

  modport master (
    input  frame_ready, q,
    output rdaddress, rden, hsync, vsync, blank_n, vga_r, vga_g, vga_b, frame_start
  );
  modport slave (
    output frame_ready, q,
    input  rdaddress, rden, hsync, vsync, blank_n, vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA timing generator and scaled reader for a 64x64 1-bit framebuffer.
// Define VGA_BORDER_EN to draw a one-pixel FG ring around the image while showing.
module vga_frame_reader #(
  parameter int          SCALE_LOG2 = 2,
  parameter int          X0         = 192,
  parameter int          Y0         = 112,
  parameter int          RD_LAT     = 2,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter int          H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int          V_VIS = 480, V_FP = 10, V_SYNC = 2,  V_BP = 33
) (
  input  logic               clock_50MHz,
  input  logic               reset_n,
  vga_frame_reader_if.master vga
);
  localparam int         IMG_PX  = 64 << SCALE_LOG2;
  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] IX0 = 10'(X0), IX1 = 10'(X0 + IMG_PX);
  localparam logic [9:0] IY0 = 10'(Y0), IY1 = 10'(Y0 + IMG_PX);
`ifdef VGA_BORDER_EN
  localparam logic [9:0] RX0 = 10'(X0 - 1), RY0 = 10'(Y0 - 1);
`endif

  typedef enum logic {WAIT = 1'b0, SHOW = 1'b1} state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic img;
    logic show;
`ifdef VGA_BORDER_EN
    logic ring;
`endif
  } scan_t;

  localparam scan_t SCAN_IDLE = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

  logic       pix_ce, first_q, frame_end;
  logic [9:0] hcount, vcount;
  state_t     state_q, state_d;
  scan_t      scan, tail;
  scan_t [RD_LAT:0] dly_pipe;
  logic [5:0] x_img, y_img;
  logic [11:0] rgb_d;

  assign frame_end = pix_ce && hcount == H_LAST && vcount == V_LAST;

  always_ff @(posedge clock_50MHz or negedge reset_n)
    if (!reset_n) begin
      pix_ce <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pix_ce <= ~pix_ce;
      if (pix_ce) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else
          hcount <= hcount + 10'd1;
      end
    end

  // Display state only moves on the frame wrap, so frames are never torn.
  always_ff @(posedge clock_50MHz or negedge reset_n)
    if (!reset_n) state_q <= WAIT;
    else          state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (frame_end)
      case (state_q)
        WAIT: if (vga.frame_ready)  state_d = SHOW;
        SHOW: if (!vga.frame_ready) state_d = WAIT;
      endcase
  end

  always_comb begin
    x_img     = 6'((hcount - IX0) >> SCALE_LOG2);
    y_img     = 6'((vcount - IY0) >> SCALE_LOG2);
    scan      = SCAN_IDLE;
    scan.hs   = !(hcount >= HS_BEG && hcount < HS_END);
    scan.vs   = !(vcount >= VS_BEG && vcount < VS_END);
    scan.vis  = hcount < H_VIS_L && vcount < V_VIS_L;
    scan.img  = hcount >= IX0 && hcount < IX1 && vcount >= IY0 && vcount < IY1;
    scan.show = state_q == SHOW;
`ifdef VGA_BORDER_EN
    scan.ring = !scan.img && hcount >= RX0 && hcount <= IX1 && vcount >= RY0 && vcount <= IY1;
`endif
  end

  // Stage 0 lines up with rdaddress; the tail lines up with q.
  always_ff @(posedge clock_50MHz or negedge reset_n)
    if (!reset_n) begin
      vga.rden      <= 1'b0;
      vga.rdaddress <= '0;
      dly_pipe      <= {(RD_LAT+1){SCAN_IDLE}};
    end else begin
      vga.rden <= scan.img && scan.show;
      if (scan.img && scan.show) vga.rdaddress <= {y_img, x_img};
      dly_pipe <= {dly_pipe[RD_LAT-1:0], scan};
    end

  assign tail = dly_pipe[RD_LAT];

  always_comb begin
    rgb_d = BG_COLOR;
    if (!tail.vis)
      rgb_d = '0;
    else if (tail.show && tail.img)
      rgb_d = vga.q ? FG_COLOR : BG_COLOR;
`ifdef VGA_BORDER_EN
    else if (tail.show && tail.ring)
      rgb_d = FG_COLOR;
`endif
  end

  // first_q makes the first clock after reset release a frame start too.
  always_ff @(posedge clock_50MHz or negedge reset_n)
    if (!reset_n) begin
      first_q         <= 1'b1;
      vga.frame_start <= 1'b0;
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.blank_n     <= 1'b0;
      {vga.vga_r, vga.vga_g, vga.vga_b} <= '0;
    end else begin
      first_q         <= 1'b0;
      vga.frame_start <= frame_end || first_q;
      vga.hsync       <= tail.hs;
      vga.vsync       <= tail.vs;
      vga.blank_n     <= tail.vis;
      {vga.vga_r, vga.vga_g, vga.vga_b} <= rgb_d;
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized bench for vga_frame_reader on a shrunken raster, checked every clock
// against a position-based model (screen point -> expected pins).
module tb_vga_frame_reader;
  localparam int SCALE_LOG2 = 0, X0 = 4, Y0 = 2, RD_LAT = 2;
  localparam int H_VIS = 70, H_FP = 2, H_SYNC = 4, H_BP = 4;
  localparam int V_VIS = 68, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FR = HT * VT;
  localparam int IMG = 64 << SCALE_LOG2;
  localparam logic [11:0] FG = 12'hA5C, BG = 12'h312;

  logic clock_50MHz = 1'b0;
  logic reset_n     = 1'b0;
  vga_frame_reader_if vif();

  vga_frame_reader #(
    .SCALE_LOG2(SCALE_LOG2), .X0(X0), .Y0(Y0), .RD_LAT(RD_LAT),
    .FG_COLOR(FG), .BG_COLOR(BG),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clock_50MHz(clock_50MHz),
    .reset_n    (reset_n),
    .vga        (vif)
  );

  always #10 clock_50MHz = ~clock_50MHz;

  logic              mem [4096];
  logic [RD_LAT-1:0] ram_pipe = '0;
  always @(posedge clock_50MHz)
    ram_pipe <= {ram_pipe[RD_LAT-2:0], vif.rden ? mem[vif.rdaddress] : 1'b0};
  assign vif.q = ram_pipe[RD_LAT-1];

  int          checks = 0, failures = 0;
  int          k, k_up, k_dn;
  bit          show_f [8];
  logic [11:0] exp_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  function automatic void pos(input int c, output int h, output int v, output int f);
    int n = c / 2;
    h = n % HT;
    v = (n / HT) % VT;
    f = n / FR;
  endfunction

  function automatic bit in_img(input int h, input int v);
    return h >= X0 && h < X0 + IMG && v >= Y0 && v < Y0 + IMG;
  endfunction

  function automatic logic [11:0] pix_addr(input int h, input int v);
    return 12'((((v - Y0) >> SCALE_LOG2) % 64) * 64 + (((h - X0) >> SCALE_LOG2) % 64));
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v, input int f);
    if (!(h < H_VIS && v < V_VIS)) return 12'h000;
    if (show_f[f] && in_img(h, v)) return mem[pix_addr(h, v)] ? FG : BG;
`ifdef VGA_BORDER_EN
    if (show_f[f] && h >= X0 - 1 && h <= X0 + IMG && v >= Y0 - 1 && v <= Y0 + IMG) return FG;
`endif
    return BG;
  endfunction

  task automatic chk_reset();
    chk("rst_hsync", 32'(vif.hsync), 32'd1);
    chk("rst_vsync", 32'(vif.vsync), 32'd1);
    chk("rst_blank", 32'(vif.blank_n), 32'd0);
    chk("rst_rgb", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'd0);
    chk("rst_rden", 32'(vif.rden), 32'd0);
    chk("rst_addr", 32'(vif.rdaddress), 32'd0);
    chk("rst_fstart", 32'(vif.frame_start), 32'd0);
  endtask

  // One clock: advance the model to edge k, then compare every pin at the falling edge.
  task automatic tick();
    int h, v, f, s;
    bit wrap, e_rden, e_hs, e_vs, e_bl;
    logic [11:0] e_rgb;
    @(posedge clock_50MHz);
    k++;
    wrap = (k % 2 == 0) && ((k / 2) % FR == 0);
    if (wrap && (k / 2) / FR < 8) show_f[(k / 2) / FR] = vif.frame_ready;
    @(negedge clock_50MHz);
    pos(k - 1, h, v, f);
    e_rden = in_img(h, v) && show_f[f];
    if (e_rden) exp_addr = pix_addr(h, v);
    chk("rden", 32'(vif.rden), 32'(e_rden));
    chk("rdaddress", 32'(vif.rdaddress), 32'(exp_addr));
    chk("frame_start", 32'(vif.frame_start), 32'(k == 1 || wrap));
    s = k - 2 - RD_LAT;
    if (s < 0) begin
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_rgb = 12'h000;
    end else begin
      pos(s, h, v, f);
      e_hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
      e_vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
      e_bl  = h < H_VIS && v < V_VIS;
      e_rgb = exp_rgb(h, v, f);
    end
    chk("hsync", 32'(vif.hsync), 32'(e_hs));
    chk("vsync", 32'(vif.vsync), 32'(e_vs));
    chk("blank_n", 32'(vif.blank_n), 32'(e_bl));
    chk("rgb", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(e_rgb));
  endtask

  task automatic model_reset();
    k = 0;
    exp_addr = '0;
    for (int i = 0; i < 8; i++) show_f[i] = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    vif.frame_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clock_50MHz);
    chk_reset();
    reset_n = 1'b1;

    // Ready rises mid frame 0 (image from frame 1), falls mid frame 1 (frame 2 blank).
    k_up = 2 * ($urandom_range(10, 60) * HT + $urandom_range(0, HT - 1));
    k_dn = 2 * FR + 2 * ($urandom_range(10, 60) * HT + $urandom_range(0, HT - 1));
    for (int i = 0; i < 6 * FR + 400; i++) begin
      tick();
      vif.frame_ready = (k >= k_up && k < k_dn);
    end

    // Reset mid-frame, then restart with ready held high and fresh image data.
    reset_n = 1'b0;
    #1;
    chk_reset();
    repeat (3) begin
      @(negedge clock_50MHz);
      chk_reset();
    end
    model_reset();
    vif.frame_ready = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 3 * FR; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
